// File: rtl/uni_bs2bin_counter.sv
// Unipolar stochastic-to-binary decoder: counts ones over 2^CNT_W qualified cycles after a SKIP flush.
// Optional macro BS2BIN_SAT_EN clamps the reported count to 2^CNT_W-1.
module uni_bs2bin_counter #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned SKIP  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             iEn,
  input  logic             iBit,
  output logic             oBusy,
  output logic             oValid,
  input  logic             iReady,
  output logic [CNT_W:0]   oCnt
);

  localparam int unsigned SKIP_W = 8;
  localparam int unsigned ACC_W  = CNT_W + 1;
`ifdef BS2BIN_SAT_EN
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {CNT_W{1'b1}}};
`endif

  typedef enum logic [1:0] {
    stIdle = 2'd0,
    stSkip = 2'd1,
    stAcc  = 2'd2,
    stDone = 2'd3
  } state_t;

  state_t              state, stateNext;
  logic [SKIP_W-1:0]   skipCnt, skipNext;
  logic [CNT_W-1:0]    winCnt, winNext;
  logic [ACC_W-1:0]    acc, accNext;
  logic [ACC_W-1:0]    cntNext;
  logic [ACC_W-1:0]    sum;
  logic [ACC_W-1:0]    finalCnt;
  logic                beginConv;
  logic                busyNext, validNext;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= stIdle;
      skipCnt <= '0;
      winCnt  <= '0;
      acc     <= '0;
      oCnt    <= '0;
      oBusy   <= 1'b0;
      oValid  <= 1'b0;
    end else begin
      state   <= stateNext;
      skipCnt <= skipNext;
      winCnt  <= winNext;
      acc     <= accNext;
      oCnt    <= cntNext;
      oBusy   <= busyNext;
      oValid  <= validNext;
    end
  end

  // Next-state, counters and output values
  always_comb begin
    stateNext = state;
    skipNext  = skipCnt;
    winNext   = winCnt;
    accNext   = acc;
    cntNext   = oCnt;
    beginConv = 1'b0;
    sum       = acc + ACC_W'(iBit);
`ifdef BS2BIN_SAT_EN
    finalCnt  = sum[CNT_W] ? SAT_MAX : sum;
`else
    finalCnt  = sum;
`endif

    case (state)
      stIdle: begin
        if (start) beginConv = 1'b1;
      end
      stSkip: begin
        if (iEn) begin
          skipNext = skipCnt + SKIP_W'(1);
          if (skipCnt == SKIP_W'(SKIP - 1)) stateNext = stAcc;
        end
      end
      stAcc: begin
        if (iEn) begin
          accNext = sum;
          winNext = winCnt + CNT_W'(1);
          if (winCnt == {CNT_W{1'b1}}) begin
            stateNext = stDone;
            cntNext   = finalCnt;
          end
        end
      end
      stDone: begin
        // oValid is high throughout DONE, so iReady alone completes the handshake
        if (iReady) begin
          if (start) beginConv = 1'b1;
          else       stateNext = stIdle;
        end
      end
      default: stateNext = stIdle;
    endcase

    if (beginConv) begin
      stateNext = (SKIP > 0) ? stSkip : stAcc;
      skipNext  = '0;
      winNext   = '0;
      accNext   = '0;
    end

    busyNext  = (stateNext == stSkip) || (stateNext == stAcc);
    validNext = (stateNext == stDone);
  end

endmodule

// File: tb/tb_uni_bs2bin_counter.sv
// Randomized self-checking bench for uni_bs2bin_counter against a count-of-qualified-bits model.
module tb_uni_bs2bin_counter;

  localparam int CNT_W = 8;
  localparam int SKIP  = 2;
  localparam int WIN   = 1 << CNT_W;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            iEn = 1'b0;
  logic            iBit = 1'b0;
  logic            iReady = 1'b0;
  logic            oBusy;
  logic            oValid;
  logic [CNT_W:0]  oCnt;

  int nChecks = 0;
  int nPass   = 0;
  int expCnt  = 0;

  uni_bs2bin_counter #(.CNT_W(CNT_W), .SKIP(SKIP)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .iEn    (iEn),
    .iBit   (iBit),
    .oBusy  (oBusy),
    .oValid (oValid),
    .iReady (iReady),
    .oCnt   (oCnt)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int modelCnt(input int ones);
`ifdef BS2BIN_SAT_EN
    return (ones > WIN - 1) ? WIN - 1 : ones;
`else
    return ones;
`endif
  endfunction

  // enMode: 0 always, 1 toggle, 2 random; bitMode: 0 zeros, 1 ones, 2 random, 3 p=1/4
  task automatic convBody(input int enMode, input int bitMode, input bit midStart);
    int  q = 0, ones = 0, cyc = 0, idle = 0;
    bit  en, b;
    bit  busyOk = 1'b1, validOk = 1'b1;
    while (q < SKIP + WIN) begin
      @(negedge clk);
      cyc++;
      if (oBusy !== 1'b1) busyOk = 1'b0;
      if (oValid !== 1'b0) validOk = 1'b0;
      iReady = 1'b0;
      case (enMode)
        0:       en = 1'b1;
        1:       en = (cyc % 2 == 0);
        default: en = ($urandom_range(0, 3) != 0);
      endcase
      case (bitMode)
        0:       b = 1'b0;
        1:       b = 1'b1;
        2:       b = 1'($urandom_range(0, 1));
        default: b = ($urandom_range(0, 3) == 0);
      endcase
      start = midStart && (q == SKIP + 100);
      iEn   = en;
      iBit  = b;
      if (en) begin
        if (q >= SKIP) ones += int'(b);
        q++;
      end else begin
        idle++;
      end
    end
    check("busyDuringConv", 32'(busyOk), 1);
    check("validDuringConv", 32'(validOk), 1);
    start = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      iEn = 1'($urandom_range(0, 1));
    end while (!oValid && cyc < SKIP + WIN + idle + 20);
    expCnt = modelCnt(ones);
    check("latency", 32'(cyc), 32'(SKIP + WIN + 1 + idle));
    check("doneValid", 32'(oValid), 1);
    check("doneBusy", 32'(oBusy), 0);
    check("doneCnt", 32'(oCnt), 32'(expCnt));
  endtask

  task automatic accept(input int hold, input bit b2b);
    bit stableOk = 1'b1;
    for (int i = 0; i < hold; i++) begin
      start = (i == 1);
      @(negedge clk);
      if (oValid !== 1'b1 || oCnt !== (CNT_W+1)'(expCnt)) stableOk = 1'b0;
    end
    if (hold > 0) check("holdStable", 32'(stableOk), 1);
    start  = b2b;
    iReady = 1'b1;
    if (!b2b) begin
      @(negedge clk);
      check("idleValid", 32'(oValid), 0);
      check("idleBusy", 32'(oBusy), 0);
      check("idleCnt", 32'(oCnt), 32'(expCnt));
      iReady = 1'b0;
      start  = 1'b0;
    end
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rstBusy", 32'(oBusy), 0);
    check("rstValid", 32'(oValid), 0);
    check("rstCnt", 32'(oCnt), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idleAfterRst", 32'(oBusy), 0);

    pulseStart();
    convBody(0, 0, 1'b0);
    accept(0, 1'b0);

    pulseStart();
    convBody(0, 1, 1'b0);
    accept(10, 1'b1);

    convBody(1, 2, 1'b1);
    accept(3, 1'b1);

    convBody(2, 3, 1'b0);
    accept(2, 1'b0);

    // Abort mid-ACC with a reset; outputs must clear without a clock edge
    pulseStart();
    for (int i = 0; i < SKIP + 100; i++) begin
      @(negedge clk);
      start = 1'b0;
      iEn   = 1'b1;
      iBit  = 1'b1;
    end
    @(negedge clk);
    check("preRstBusy", 32'(oBusy), 1);
    check("preRstCnt", 32'(oCnt), 32'(expCnt));
    rst = 1'b1;
    #1;
    check("asyncRstBusy", 32'(oBusy), 0);
    check("asyncRstValid", 32'(oValid), 0);
    check("asyncRstCnt", 32'(oCnt), 0);
    @(negedge clk);
    rst = 1'b0;

    pulseStart();
    convBody(2, 2, 1'b0);
    accept(1, 1'b0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/uni_bs2bin_counter.md
# uni_bs2bin_counter

Unipolar stochastic-to-binary decoder for the MAC16 datapath. It consumes the single-bit unipolar stream produced by a stochastic MAC (gMUL_uni array followed by orADD) and counts ones over a fixed window of 2^CNT_W qualified cycles. It then presents the binary count through a valid/ready handshake. It is the read-back end of the binary-to-stochastic encoding done by the Sobol-driven multipliers, and sits between the MAC and the binary result buffer.

## Interface
Parameters:
- CNT_W, default 8: log2 of the window length; matches the 8-bit Sobol sequence period (256 cycles).
- SKIP, default 2, range 0..255: qualified cycles discarded after start to flush the multiplier/adder pipeline registers.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high; while high, all state and outputs are held at reset values.
- start  input  1  single-cycle request to begin a conversion; sampled only in IDLE or in the accepting DONE cycle.
- iEn  input  1  stream qualifier; a cycle counts toward SKIP or the window only when iEn=1.
- iBit  input  1  stochastic bit from the MAC; sampled only when iEn=1 in ACC.
- oBusy  output  1  high in SKIP and ACC.
- oValid  output  1  high in DONE.
- iReady  input  1  consumer accepts oCnt when oValid&&iReady.
- oCnt  output  CNT_W+1  number of ones in the window.

## Operation
- FSM states are IDLE, SKIP, ACC and DONE; the reset state is IDLE.
- Reset values: oBusy=0, oValid=0, oCnt=0; internal skip counter, window counter and accumulator are all 0.
- IDLE with start=1: go to SKIP if SKIP>0, else go to ACC. Clear the accumulator and counters.
- SKIP: each cycle with iEn=1 increments the skip counter. On the SKIP-th qualified cycle, go to ACC. iBit is ignored.
- ACC: each cycle with iEn=1 adds iBit to the accumulator and increments the window counter. On the 2^CNT_W-th qualified cycle, go to DONE with the final sum registered into oCnt.
- iEn=0 cycles freeze all counters and the accumulator, and the FSM stays in its state (pause, not abort).
- DONE: oValid=1 and oCnt stays stable until handshake.
  - oValid&&iReady with start=0: go to IDLE.
  - oValid&&iReady with start=1: go directly to SKIP/ACC (back-to-back conversion, no idle bubble).
- start in SKIP or ACC, or in DONE without iReady, is ignored.
- oCnt holds its last value in IDLE and is updated only on entry to DONE.
- Accumulator width is CNT_W+1 so that 2^CNT_W (all-ones stream) is representable; the window counter wraps internally and is cleared on start.
- rst asserted mid-conversion forces IDLE immediately. The partial count is discarded and oCnt=0.

## Timing
- Latency with iEn held at 1, start high in cycle 0:
  - SKIP occupies cycles 1..SKIP.
  - ACC occupies cycles SKIP+1..SKIP+2^CNT_W.
  - oValid=1 from cycle SKIP+2^CNT_W+1.
  - Defaults: oValid=1 first at cycle 259.
- Each iEn=0 cycle inside SKIP/ACC adds exactly one cycle of latency.
- Throughput with back-to-back handshake: one result per SKIP+2^CNT_W+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro BS2BIN_SAT_EN.
- Defined: oCnt is clamped to 2^CNT_W−1. An all-ones window reports 255 (defaults), and oCnt[CNT_W] is always 0, giving a direct 8-bit unipolar value.
- Undefined: the raw count 0..2^CNT_W is reported, so an all-ones window gives 256.

## Test plan
- Reset then start, iEn=1, iBit=0 constant -> oValid at cycle 259, oCnt=0, oBusy low from cycle 259.
- iBit=1 constant -> oCnt=256 without BS2BIN_SAT_EN, 255 with it; the first 2 iBit cycles after start are ignored (drive them 0 and the count is unchanged).
- iBit driven by the MAC with iA=iB=128 on one lane, others 0 -> oCnt within ±8 of 64.
- iEn toggled 0/1 every cycle during ACC -> same oCnt as the iEn=1 run for the same qualified bit sequence; oValid at cycle 517.
- iReady held low 10 cycles in DONE, then start and iReady together -> oCnt stable throughout; the next conversion's SKIP begins the following cycle; a start pulsed mid-ACC is ignored.
- rst pulsed at cycle 100 of ACC -> oBusy=0, oValid=0, oCnt=0 asynchronously; a later start gives a full, correct conversion.
